qr_inv: RTL and testbench

//  Iterative inverse of the ChaCha quarter round: takes a post-QR word set (a,b,c,d)
//  and recovers the pre-QR inputs. Sits beside the combinational forward QR as its

---
 rtl/qr_inv.sv | 85 ++++++++
 tb/tb_qr_inv.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/qr_inv.sv
// qr_inv: iterative inverse ChaCha quarter round, one sub-step per clock
module qr_inv #(
    parameter int NUM_QR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [4:0] LAST = 5'(NUM_QR - 1);
    state_t state, state_nxt;
    logic [31:0] a, b, c, d, a_nxt, b_nxt, c_nxt, d_nxt, b_rot, d_rot;
    logic [1:0] step;
    logic [4:0] round;
    logic last_step;
    assign in_ready  = rst_n && state == IDLE;
    assign busy      = state == RUN;
    assign last_step = step == 2'd3 && round == LAST;
    // Even steps undo the b/c half, odd steps the d/a half; step[1] picks the rotation pair
    always_comb begin
        b_rot = step[1] ? {b[11:0], b[31:12]} : {b[6:0], b[31:7]};
        d_rot = step[1] ? {d[15:0], d[31:16]} : {d[7:0], d[31:8]};
        b_nxt = step[0] ? b : b_rot ^ c;
        c_nxt = step[0] ? c : c - d;
        d_nxt = step[0] ? d_rot ^ a : d;
        a_nxt = step[0] ? a - b : a;
    end
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid ? RUN : IDLE;
            RUN:     state_nxt = last_step ? DONE : RUN;
            DONE:    state_nxt = (out_valid && out_ready) ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    // Working registers, step/round counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {a, b, c, d} <= '0;
            {a_out, b_out, c_out, d_out} <= '0;
            step      <= '0;
            round     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    {a, b, c, d} <= {a_in, b_in, c_in, d_in};
                    step  <= '0;
                    round <= '0;
                end
                RUN: begin
                    {a, b, c, d} <= {a_nxt, b_nxt, c_nxt, d_nxt};
                    step <= step + 2'd1;
                    if (step == 2'd3 && !last_step) round <= round + 5'd1;
                end
                DONE: if (!out_valid) begin
                    out_valid <= 1'b1;
                    {a_out, b_out, c_out, d_out} <= {a, b, c, d};
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_qr_inv.sv
// tb_qr_inv: vector, round-trip, backpressure and reset checks for qr_inv
module tb_qr_inv;
    logic clk = 0, rst_n = 0;
    logic in_valid = 0, out_ready = 1, in_ready, out_valid, busy;
    logic [31:0] a_in = 0, b_in = 0, c_in = 0, d_in = 0, a_out, b_out, c_out, d_out;
    logic in_valid2 = 0, out_ready2 = 1, in_ready2, out_valid2, busy2;
    logic [31:0] a_in2 = 0, b_in2 = 0, c_in2 = 0, d_in2 = 0, a_out2, b_out2, c_out2, d_out2;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    qr_inv #(.NUM_QR(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out), .busy(busy));

    qr_inv #(.NUM_QR(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_in(a_in2), .b_in(b_in2), .c_in(c_in2), .d_in(d_in2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .a_out(a_out2), .b_out(b_out2), .c_out(c_out2), .d_out(d_out2), .busy(busy2));

    typedef struct packed {
        logic [127:0] i;
        logic [127:0] e;
    } vec_t;

    function automatic logic [31:0] rotl(logic [31:0] x, int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Forward ChaCha quarter round as written in RFC 7539
    function automatic logic [127:0] fwd(logic [127:0] v);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = v;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the NUM_QR=1 instance with out_ready held high
    task automatic xact(input logic [127:0] v, output logic [127:0] r, output int lat, output int bad);
        int n = 0, bc;
        bad = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        if (!in_ready) bad++;
        {a_in, b_in, c_in, d_in} = v;
        in_valid = 1;
        tick();
        in_valid = 0;
        if (in_ready) bad++;
        bc = busy;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
            bc += busy;
            if (in_ready) bad++;
        end
        r = {a_out, b_out, c_out, d_out};
        if (bc != 4) bad++;
        tick();
        if (out_valid || !in_ready) bad++;
    endtask

    localparam logic [127:0] RFC_PRE  = 128'h11111111_01020304_9b8d6f43_01234567;
    localparam logic [127:0] RFC_POST = 128'hea2a92f4_cb1cf8ce_4581472e_5881c4bb;

    initial begin
        vec_t tbl[4];
        logic [127:0] r, p, snap;
        int lat, bad, cnt;
        tbl[0] = '{i: RFC_POST, e: RFC_PRE};
        tbl[1] = '{i: '0, e: '0};
        p = 128'hffffffff_00000001_80000000_fffffffe;
        tbl[2] = '{i: fwd(p), e: p};
        p = 128'h00000000_ffffffff_00000001_ffffffff;
        tbl[3] = '{i: fwd(p), e: p};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {in_ready, out_valid, busy}, 3'b000);
        check("reset_out", {a_out, b_out, c_out, d_out}, '0);
        rst_n = 1;
        #1;
        check("reset_release_ready", in_ready, 1'b1);
        check("model_rfc", fwd(RFC_PRE), RFC_POST);

        for (int k = 0; k < 4; k++) begin
            xact(tbl[k].i, r, lat, bad);
            check($sformatf("vec%0d_data", k), r, tbl[k].e);
            check($sformatf("vec%0d_latency", k), lat, 5);
            check($sformatf("vec%0d_ctl", k), bad, 0);
        end

        for (int k = 0; k < 1000; k++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            xact(fwd(p), r, lat, bad);
            check($sformatf("rt%0d", k), {r, 32'(lat), 32'(bad)}, {p, 32'd5, 32'd0});
        end

        out_ready = 0;
        {a_in, b_in, c_in, d_in} = RFC_POST;
        in_valid = 1;
        tick();
        in_valid = 0;
        cnt = 0;
        while (!out_valid && cnt < 50) begin tick(); cnt++; end
        check("bp_latency", cnt, 5);
        snap = {a_out, b_out, c_out, d_out};
        check("bp_data", snap, RFC_PRE);
        bad = 0;
        for (int k = 0; k < 7; k++) begin
            in_valid = k[0];
            {a_in, b_in, c_in, d_in} = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (!out_valid || in_ready || busy || {a_out, b_out, c_out, d_out} != snap) bad++;
        end
        in_valid = 0;
        check("bp_stable", bad, 0);
        out_ready = 1;
        tick();
        check("bp_release", {out_valid, in_ready, busy}, 3'b010);
        check("bp_hold", {a_out, b_out, c_out, d_out}, snap);
        repeat (3) tick();
        check("bp_no_junk", {out_valid, in_ready, busy}, 3'b010);

        {a_in, b_in, c_in, d_in} = RFC_POST;
        in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        tick();
        check("rst_mid_busy", busy, 1'b1);
        rst_n = 0;
        #2;
        check("rst_mid_asserted", {in_ready, out_valid, busy}, 3'b000);
        tick();
        rst_n = 1;
        #1;
        check("rst_mid_ctl", {out_valid, in_ready, busy}, 3'b010);
        check("rst_mid_out", {a_out, b_out, c_out, d_out}, '0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin tick(); cnt += out_valid; end
        check("rst_no_stale", cnt, 0);

        cnt = 0;
        while (!in_ready2 && cnt < 20) begin tick(); cnt++; end
        {a_in2, b_in2, c_in2, d_in2} = fwd(fwd(RFC_PRE));
        in_valid2 = 1;
        tick();
        in_valid2 = 0;
        cnt = 0;
        while (!out_valid2 && cnt < 50) begin tick(); cnt++; end
        check("qr2_latency", cnt, 9);
        check("qr2_data", {a_out2, b_out2, c_out2, d_out2}, RFC_PRE);
        tick();
        check("qr2_release", {out_valid2, in_ready2}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
